// File: rtl/iter_div_pkg.sv
// Shared types, constants and helpers for the iterative divider.
// Operand widths up to MAX_W bits are supported by the helpers below.
package iter_div_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_TAG_W = 5;
  localparam int unsigned MAX_W     = 64;

  // Controller states
  typedef logic [1:0] div_state_t;
  localparam div_state_t IDLE = 2'd0;
  localparam div_state_t CALC = 2'd1;
  localparam div_state_t DONE = 2'd2;

  // Quotient returned for a zero divisor (all ones, sliced to WIDTH by the user)
  localparam logic [MAX_W-1:0] DBZ_QUOT = '1;

  // Two's-complement negate when neg is set. Only the low bits of the result depend on the low
  // bits of v, so callers zero-extend a narrower value and truncate the result back.
  function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/iter_div_lzc.sv
// Leading-zero counter for the early-out path of the iterative divider.
// An all-zero input returns WIDTH.
module iter_div_lzc
  import iter_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] count
);

  // Scan upward so the most significant set bit determines the count
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) begin
        count = CNT_W'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/iter_div_unit.sv
// Multi-cycle radix-2 restoring divider for the EXE stage.
// Signed/unsigned division returning quotient and remainder together, valid/ready on both sides,
// pipeline flush and an opaque tag carried from request to result.
// Optional feature: define ITER_DIV_EARLY_OUT_EN to skip the leading-zero iterations of the
// dividend (results identical, latency shorter).
module iter_div_unit
  import iter_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned TAG_W = DEF_TAG_W,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             busy
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [WIDTH-1:0] oquot_q, oquot_d;
  logic [WIDTH-1:0] orem_q, orem_d;
  logic [TAG_W-1:0] otag_q, otag_d;
  logic             odbz_q, odbz_d;

  logic             accept;
  logic             dvd_neg, dsr_neg, dsr_zero;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic [WIDTH-1:0] init_quo;
  logic [CNT_W-1:0] init_cnt;

  logic [WIDTH:0]   shifted, trial;
  logic             step_ok;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] fin_quo, fin_rem;

  // Handshake: a result leaving in the same cycle frees the unit for a new request
  assign in_ready  = ((state_q == IDLE) | ((state_q == DONE) & out_ready)) & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_quot  = oquot_q;
  assign out_rem   = orem_q;
  assign out_tag   = otag_q;
  assign out_dbz   = odbz_q;

  // Operand magnitudes; negation only for signed requests with the MSB set
  assign dvd_neg  = in_signed & in_dividend[WIDTH-1];
  assign dsr_neg  = in_signed & in_divisor[WIDTH-1];
  assign dvd_mag  = WIDTH'(twos_neg(MAX_W'(in_dividend), dvd_neg));
  assign dsr_mag  = WIDTH'(twos_neg(MAX_W'(in_divisor), dsr_neg));
  assign dsr_zero = (in_divisor == '0);

`ifdef ITER_DIV_EARLY_OUT_EN
  logic [CNT_W-1:0] lz;

  iter_div_lzc #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_lzc (
    .value (dvd_mag),
    .count (lz)
  );

  // Leading zeros would only shift zeros into the remainder; skip them, keeping at least one
  // iteration so a zero dividend still passes through CALC.
  assign init_quo = dvd_mag << lz;
  assign init_cnt = (lz >= CNT_W'(WIDTH)) ? CNT_W'(1) : (CNT_W'(WIDTH) - lz);
`else
  assign init_quo = dvd_mag;
  assign init_cnt = CNT_W'(WIDTH);
`endif

  // One restoring step: shift {rem,quo} left, subtract the divisor at WIDTH+1 bits
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dsr_q};
    step_ok  = ~trial[WIDTH];
    // rem < divisor is invariant, so a successful trial always fits in WIDTH bits
    step_rem = step_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], step_ok};
    fin_quo  = WIDTH'(twos_neg(MAX_W'(step_quo), qneg_q));
    fin_rem  = WIDTH'(twos_neg(MAX_W'(step_rem), rneg_q));
  end

  // Controller and datapath next state; flush overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    tag_d   = tag_q;
    oquot_d = oquot_q;
    orem_d  = orem_q;
    otag_d  = otag_q;
    odbz_d  = odbz_q;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CALC: begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = DONE;
            oquot_d = fin_quo;
            orem_d  = fin_rem;
            otag_d  = tag_q;
            odbz_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: ;
      endcase

      // Accept is only possible from IDLE or a completing DONE, so it takes precedence here
      if (accept) begin
        if (dsr_zero) begin
          state_d = DONE;
          cnt_d   = '0;
          oquot_d = DBZ_QUOT[WIDTH-1:0];
          orem_d  = in_dividend;
          otag_d  = in_tag;
          odbz_d  = 1'b1;
        end else begin
          state_d = CALC;
          cnt_d   = init_cnt;
          rem_d   = '0;
          quo_d   = init_quo;
          dsr_d   = dsr_mag;
          qneg_d  = dvd_neg ^ dsr_neg;
          rneg_d  = dvd_neg;
          tag_d   = in_tag;
        end
      end
    end
  end

  // State registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      tag_q   <= '0;
      oquot_q <= '0;
      orem_q  <= '0;
      otag_q  <= '0;
      odbz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      tag_q   <= tag_d;
      oquot_q <= oquot_d;
      orem_q  <= orem_d;
      otag_q  <= otag_d;
      odbz_q  <= odbz_d;
    end
  end

endmodule
